// File: rtl/data_register_if.sv
// Write-port bundle for one register of the register file: load enable,
// write data, and the stored value read back out.
interface data_register_if #(
   parameter int unsigned WIDTH = 32
);
   logic             writeEnable;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] dataOut;

   // Register-file side: drives the write port, observes the stored value.
   modport master (
      output writeEnable,
      output dataIn,
      input  dataOut
   );

   // Register side: accepts the write port, presents the stored value.
   modport slave (
      input  writeEnable,
      input  dataIn,
      output dataOut
   );
endinterface : data_register_if

// File: rtl/data_register.sv
// Word-wide storage register with synchronous load enable and asynchronous
// active-low clear. One instance per architectural register x1..x31.
module data_register #(
   parameter int unsigned     WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic            clk,
   input logic            reset,   // active-low, asynchronous
   data_register_if.slave bus
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // Next value: load write data when enabled, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (bus.writeEnable) begin
         data_d = bus.dataIn;
      end
   end

   // Storage flops; the asynchronous clear overrides any coincident load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   // Output taken straight from the flops, no bypass from the write port.
   assign bus.dataOut = data_q;

endmodule : data_register

// File: tb/tb_data_register.sv
// Scoreboard bench for data_register: three instances (default, non-zero
// reset value, 8-bit) share stimulus; a monitor compares against a model.
module tb_data_register;

   localparam logic [31:0] RV_DEF = 32'h0000_0000;
   localparam logic [31:0] RV_ALT = 32'h0000_1000;
   localparam logic [7:0]  RV_8   = 8'h00;

   typedef struct {
      string       tag;
      logic [31:0] e32;
      logic [31:0] erv;
      logic [7:0]  e8;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [31:0] din;

   int unsigned n_checks;
   int unsigned n_pass;

   exp_t        exp_q[$];
   event        sample_ev;

   // Reference model state: what each register should hold right now.
   logic [31:0] m32;
   logic [31:0] mrv;
   logic [7:0]  m8;

   data_register_if #(.WIDTH(32)) if32 ();
   data_register_if #(.WIDTH(32)) ifrv ();
   data_register_if #(.WIDTH(8))  if8  ();

   assign if32.writeEnable = we;
   assign if32.dataIn      = din;
   assign ifrv.writeEnable = we;
   assign ifrv.dataIn      = din;
   assign if8.writeEnable  = we;
   assign if8.dataIn       = din[7:0];

   data_register #(.WIDTH(32), .RESET_VALUE(RV_DEF)) dut32 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (if32)
   );

   data_register #(.WIDTH(32), .RESET_VALUE(RV_ALT)) dutrv (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifrv)
   );

   data_register #(.WIDTH(8), .RESET_VALUE(RV_8)) dut8 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (if8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the run is a fixed sequence, so this only trips on a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- model helpers ----------------
   function automatic void model_reset();
      m32 = RV_DEF;
      mrv = RV_ALT;
      m8  = RV_8;
   endfunction

   // What a rising edge does to the register given the inputs at that edge.
   function automatic void model_edge();
      if (!rst_n) begin
         model_reset();
      end else if (we) begin
         m32 = din;
         mrv = din;
         m8  = din[7:0];
      end
   endfunction

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag = tag;
      e.e32 = m32;
      e.erv = mrv;
      e.e8  = m8;
      exp_q.push_back(e);
      ->sample_ev;
   endtask

   // ---------------- stimulus helpers ----------------
   // Apply inputs half a cycle before the next edge; a reset drop acts at once.
   task automatic drive(input logic r, input logic w, input logic [31:0] d);
      @(negedge clk);
      rst_n = r;
      we    = w;
      din   = d;
      if (!r) model_reset();
   endtask

   // Let one rising edge pass and expect its effect.
   task automatic edge_chk(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      push_exp(tag);
   endtask

   task automatic step(input logic r, input logic w, input logic [31:0] d, input string tag);
      drive(r, w, d);
      edge_chk(tag);
   endtask

   // Expect the current value without an edge passing.
   task automatic peek(input string tag);
      #1;
      push_exp(tag);
   endtask

   // Drop reset between clock edges and expect the clear before the next edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      peek(tag);
   endtask

   // Drop reset exactly on a loading edge: reset must win.
   task automatic collide(input logic [31:0] d, input string tag);
      drive(1'b1, 1'b1, d);
      @(posedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      push_exp(tag);
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Pop each expected snapshot and compare all three instances against it.
   initial begin
      forever begin
         @(sample_ev);
         while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "/w32"}, if32.dataOut, e.e32);
            chk({e.tag, "/rv"},  ifrv.dataOut, e.erv);
            chk({e.tag, "/w8"},  {24'h0, if8.dataOut}, {24'h0, e.e8});
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b1;
      we       = 1'b1;
      din      = 32'hFFFF_FFFF;
      m32      = 'x;
      mrv      = 'x;
      m8       = 'x;

      // Reset held with a write pending must keep the reset value.
      #1;
      rst_n = 1'b0;
      model_reset();
      peek("rst_async");
      step(1'b0, 1'b1, 32'hFFFF_FFFF, "rst_hold0");
      step(1'b0, 1'b1, 32'hFFFF_FFFF, "rst_hold1");
      step(1'b1, 1'b0, 32'hFFFF_FFFF, "rst_release");

      // Single load: one-cycle latency, then hold while dataIn toggles.
      drive(1'b1, 1'b1, 32'hDEAD_BEEF);
      peek("load_pre_edge");
      edge_chk("load_post_edge");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h1234_5678 ^ 32'(i), "hold");
      end

      // Back-to-back writes: each value appears one edge after its load.
      step(1'b1, 1'b1, 32'h0000_0001, "b2b_0");
      step(1'b1, 1'b1, 32'h8000_0000, "b2b_1");
      step(1'b1, 1'b1, 32'hA5A5_5A5A, "b2b_2");

      // Mid-cycle asynchronous clear, then reload.
      async_reset("async_mid");
      step(1'b1, 1'b0, 32'h0, "async_release");
      step(1'b1, 1'b1, 32'h0000_00FF, "async_reload");

      // Reset coinciding with a loading edge.
      collide(32'hCAFE_F00D, "collide");
      peek("collide_after");
      step(1'b1, 1'b0, 32'h0, "collide_release");

      // Narrow-instance extremes.
      step(1'b1, 1'b1, 32'h0000_00FF, "w8_ff");
      step(1'b1, 1'b1, 32'h0000_0000, "w8_00");

      // Randomized traffic with occasional resets and pre-edge peeks.
      for (int i = 0; i < 200; i++) begin
         logic        r;
         logic        w;
         logic [31:0] d;
         r = ($urandom_range(0, 15) != 0);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         if ($urandom_range(0, 24) == 0) begin
            async_reset("rand_async");
         end
         drive(r, w, d);
         if ($urandom_range(0, 3) == 0) peek("rand_pre_edge");
         edge_chk("rand");
      end

      #20;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_data_register
